bus_arbiter: RTL and testbench
==============================

// Module: bus_arbiter
// PURPOSE
//  Grants the shared serial bus (12-bit serial address + 8-bit serial data, valid/ready) to one of
//  NUM_MASTERS master ports. Holds the grant for one whole transaction, releases on slave completion
//  or timeout, then re-arbitrates. Only the granted master's output port may drive the bus.
// PARAMETERS
//  NUM_MASTERS    2      number of requesting masters, 2..8; ID_W = $clog2(NUM_MASTERS)
//  PRIORITY_MODE  0      0 = fixed priority (lowest index wins), 1 = round-robin
//  TIMEOUT        1000   max cycles in GRANT+BUSY before forced release, 1..65535; 0 disables timeout
// PORTS
//  clk          in   1         clock, all state changes on posedge
//  reset        in   1         asynchronous, active-high
//  req          in   N         per-master bus request, level, held until transaction done
//  m_valid      in   N         per-master master_valid (first address handshake of a transaction)
//  slave_done   in   1         1-cycle pulse: addressed slave finished the current transaction
//  grant        out  N         one-hot grant, registered; all zero when no owner
//  grant_id     out  ID_W      index of current/last owner, registered
//  bus_busy     out  1         1 in GRANT and BUSY states
//  timeout_err  out  1         1-cycle pulse, asserted in the RELEASE cycle after a forced release
// BEHAVIOUR
//  Reset (async): state IDLE, grant=0, grant_id=0, bus_busy=0, timeout_err=0, rr pointer=0, timer=0.
//  FSM (4 states, registered outputs):
//   IDLE    : grant=0. If |req at posedge, pick winner, go GRANT; grant/grant_id valid next cycle.
//   GRANT   : grant[owner]=1. m_valid[owner]=1 -> BUSY. req[owner]=0 -> RELEASE (no error).
//             timer reaches TIMEOUT -> RELEASE with timeout_err.
//   BUSY    : grant held; req changes ignored. slave_done -> RELEASE. timer reaches TIMEOUT ->
//             RELEASE with timeout_err.
//   RELEASE : grant=0 for exactly 1 cycle (bus turnaround); rr pointer <= owner+1 (wrap to 0 past
//             N-1); next state IDLE.
//  Arbitration: mode 0 -> lowest set req index. Mode 1 -> first set req at/after rr pointer, wrapping.
//   Pointer only updates in RELEASE, so a lone requester may be regranted back to back.
//  Timer: 16-bit, cleared on entry to GRANT, +1 each cycle in GRANT/BUSY; forced release when
//   timer == TIMEOUT-1 and no release condition, so grant lasts exactly TIMEOUT cycles max.
//  Latency: req sampled at edge k -> grant high after edge k. Release event at edge k -> grant low
//   after edge k; earliest next grant after edge k+2 (RELEASE, IDLE).
//  Priorities in one cycle: slave_done or req drop beats timeout (no timeout_err);
//   in GRANT, m_valid[owner] beats req drop.
//  slave_done in IDLE/GRANT/RELEASE ignored. m_valid from non-owners ignored.
//  grant_id keeps the last owner while grant=0 (debug use).
//  Reset mid-transaction: grant drops asynchronously, in-flight transfer abandoned, pointer=0.
//  Invariant: $onehot0(grant) every cycle; grant!=0 only in GRANT/BUSY.
// TESTING
//  1 Single master: req=01 at cyc0 -> grant=01, grant_id=0, bus_busy=1 from cyc1; m_valid[0]
//    cyc3 -> BUSY; slave_done cyc25 -> grant=00 cyc26, timeout_err stays 0.
//  2 Fixed priority (mode 0): req=11 held, 3 transactions -> owners 0,0,0; master 1 never granted.
//  3 Round-robin (mode 1): req=11 held, 4 transactions -> owners 0,1,0,1; 1-cycle zero-grant gap each.
//  4 Timeout (TIMEOUT=10): req=01, never m_valid -> grant high exactly 10 cycles, then timeout_err
//    pulse 1 cycle with grant=00; also BUSY with no slave_done -> same result.
//  5 Coincidence: slave_done on the cycle timer hits TIMEOUT-1 -> normal release, timeout_err=0.
//  6 Reset mid-BUSY (owner=1, mode 1) -> grant=00 immediately; after reset req=11 -> master 0 granted.

Source files
------------

// File: rtl/bus_arbiter.sv
// bus_arbiter: hands the shared serial bus to one of NUM_MASTERS masters for a
// whole transaction. The grant is released on slave completion, on the owner
// dropping its request before its first handshake, or on timeout. After a
// release the bus turns around for one cycle before it is arbitrated again.
//
// state   | meaning
// IDLE    | no owner; arbitrate among pending requests
// GRANT   | owner granted, waiting for its first address handshake
// BUSY    | transaction in flight, waiting for slave_done
// RELEASE | one-cycle turnaround with grant low; advance rr pointer
module bus_arbiter #(
  parameter int NUM_MASTERS   = 2,
  parameter int PRIORITY_MODE = 0,
  parameter int TIMEOUT       = 1000,
  localparam int ID_W         = $clog2(NUM_MASTERS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [NUM_MASTERS-1:0] m_valid,
  input  logic                   slave_done,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [ID_W-1:0]        grant_id,
  output logic                   bus_busy,
  output logic                   timeout_err
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_BUSY    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  localparam logic [NUM_MASTERS-1:0] ONE      = NUM_MASTERS'(1);
  localparam logic [ID_W-1:0]        LAST_ID  = ID_W'(NUM_MASTERS - 1);
  localparam bit                     TMO_EN   = (TIMEOUT > 0);
  localparam logic [15:0]            TMO_LAST = (TIMEOUT > 0) ? 16'(TIMEOUT - 1) : 16'd0;

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [15:0]     timer;

  logic [ID_W-1:0] search_base;
  logic [ID_W-1:0] winner;
  logic            found;
  int              idx;

  logic            owner_req;
  logic            owner_valid;
  logic            timeout_hit;

  // Fixed priority is a round-robin search that always starts at index 0.
  assign search_base = (PRIORITY_MODE == 1) ? rr_ptr : '0;

  // The grant is one-hot while owned, so masking selects the owner's own bits.
  assign owner_req   = |(req & grant);
  assign owner_valid = |(m_valid & grant);
  assign timeout_hit = TMO_EN && (timer == TMO_LAST);

  // First requester at or after the search base, wrapping past the top index.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      idx = int'(search_base) + k;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      if (!found && ((req & (ONE << idx)) != '0)) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

  // Arbitration FSM with registered grant, busy, error pulse, timer and rr pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      grant       <= '0;
      grant_id    <= '0;
      bus_busy    <= 1'b0;
      timeout_err <= 1'b0;
      rr_ptr      <= '0;
      timer       <= '0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|req) begin
            state    <= ST_GRANT;
            grant    <= ONE << winner;
            grant_id <= winner;
            bus_busy <= 1'b1;
            timer    <= '0;
          end
        end

        ST_GRANT: begin
          // A handshake on the last allowed cycle cannot extend the grant.
          if (owner_valid && !timeout_hit) begin
            state <= ST_BUSY;
            timer <= timer + 16'd1;
          end else if (!owner_req) begin
            state    <= ST_RELEASE;
            grant    <= '0;
            bus_busy <= 1'b0;
          end else if (timeout_hit) begin
            state       <= ST_RELEASE;
            grant       <= '0;
            bus_busy    <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            timer <= timer + 16'd1;
          end
        end

        ST_BUSY: begin
          if (slave_done) begin
            state    <= ST_RELEASE;
            grant    <= '0;
            bus_busy <= 1'b0;
          end else if (timeout_hit) begin
            state       <= ST_RELEASE;
            grant       <= '0;
            bus_busy    <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            timer <= timer + 16'd1;
          end
        end

        ST_RELEASE: begin
          state  <= ST_IDLE;
          rr_ptr <= (grant_id == LAST_ID) ? '0 : grant_id + ID_W'(1);
        end

        default: begin
          state    <= ST_IDLE;
          grant    <= '0;
          bus_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: randomized transactions on two arbiters (fixed priority with
// four masters and TIMEOUT=10, round-robin with three masters and TIMEOUT=37),
// checked by a scoreboard against a transaction-level reference model.
`timescale 1ns/1ps
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset;

  logic [3:0] req0, mv0, gnt0;
  logic       sd0, busy0, terr0;
  logic [1:0] gid0;

  logic [2:0] req1, mv1, gnt1;
  logic       sd1, busy1, terr1;
  logic [1:0] gid1;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b1;
  int rr_ptr1  = 0;

  typedef struct {
    int owner;
    int len;
    bit terr;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  bus_arbiter #(.NUM_MASTERS(4), .PRIORITY_MODE(0), .TIMEOUT(10)) u_fix (
    .clk(clk), .reset(reset), .req(req0), .m_valid(mv0), .slave_done(sd0),
    .grant(gnt0), .grant_id(gid0), .bus_busy(busy0), .timeout_err(terr0)
  );

  bus_arbiter #(.NUM_MASTERS(3), .PRIORITY_MODE(1), .TIMEOUT(37)) u_rr (
    .clk(clk), .reset(reset), .req(req1), .m_valid(mv1), .slave_done(sd1),
    .grant(gnt1), .grant_id(gid1), .bus_busy(busy1), .timeout_err(terr1)
  );

  function automatic int n_of(input int d);
    return (d == 0) ? 4 : 3;
  endfunction

  function automatic int tmo_of(input int d);
    return (d == 0) ? 10 : 37;
  endfunction

  function automatic logic [3:0] gnt_of(input int d);
    return (d == 0) ? gnt0 : {1'b0, gnt1};
  endfunction

  function automatic logic [1:0] gid_of(input int d);
    return (d == 0) ? gid0 : gid1;
  endfunction

  function automatic logic busy_of(input int d);
    return (d == 0) ? busy0 : busy1;
  endfunction

  function automatic logic terr_of(input int d);
    return (d == 0) ? terr0 : terr1;
  endfunction

  task automatic set_in(input int d, input logic [3:0] r, input logic [3:0] mv, input logic sd);
    if (d == 0) begin
      req0 = r; mv0 = mv; sd0 = sd;
    end else begin
      req1 = r[2:0]; mv1 = mv[2:0]; sd1 = sd;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // Reference arbitration: first requester scanning from the start index.
  function automatic int model_pick(input int d, input logic [3:0] r);
    int nm, start, idx;
    nm    = n_of(d);
    start = (d == 0) ? 0 : rr_ptr1;
    for (int k = 0; k < nm; k++) begin
      idx = (start + k) % nm;
      if ((r & (4'b0001 << idx)) != 4'b0000) return idx;
    end
    return -1;
  endfunction

  function automatic int idx_of(input logic [3:0] g);
    for (int i = 0; i < 4; i++)
      if ((g & (4'b0001 << i)) != 4'b0000) return i;
    return -1;
  endfunction

  // Stimulus: plan a transaction, push its expected outcome, then play master.
  task automatic drive(input int d);
    int nm, tmo, w, kind, a, s, len;
    bit terr, ok;
    logic [3:0] r, rr, mv, own;
    logic sd;
    exp_t e;
    nm  = n_of(d);
    tmo = tmo_of(d);
    for (int t = 0; t < 80; t++) begin
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
        @(negedge clk);
        if (gnt_of(d) == 4'b0000) begin ok = 1'b1; break; end
      end
      if (!ok) fail_now($sformatf("dut%0d_wait_release", d));

      r = 4'($urandom_range(1, (1 << nm) - 1));
      if ($urandom_range(0, 2) == 0) r = (d == 0) ? 4'hF : 4'h7;
      w = model_pick(d, r);

      kind = int'($urandom_range(0, 3));
      a = 0; s = 0; len = tmo; terr = 1'b1;
      case (kind)
        0: begin
          a = int'($urandom_range(0, tmo - 3));
          s = int'($urandom_range(a + 1, tmo - 1));
          if ($urandom_range(0, 3) == 0) s = tmo - 1;
          len = s + 1; terr = 1'b0;
        end
        1: begin
          a = int'($urandom_range(0, tmo - 1));
          if ($urandom_range(0, 3) == 0) a = tmo - 1;
          len = a + 1; terr = 1'b0;
        end
        2: begin
          len = tmo; terr = 1'b1;
        end
        default: begin
          a = int'($urandom_range(0, tmo - 3));
          len = tmo; terr = 1'b1;
        end
      endcase

      e.owner = w; e.len = len; e.terr = terr;
      if (d == 0) q0.push_back(e);
      else begin
        q1.push_back(e);
        rr_ptr1 = (w + 1) % nm;
      end

      set_in(d, r, 4'b0000, 1'b0);
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (gnt_of(d) != 4'b0000) begin ok = 1'b1; break; end
      end
      if (!ok) fail_now($sformatf("dut%0d_wait_grant", d));

      own = 4'b0001 << w;
      for (int c = 0; c < len; c++) begin
        rr = 4'($urandom) & ~own;
        mv = 4'($urandom) & ~own;
        sd = 1'($urandom);
        case (kind)
          0, 3: begin
            if (c < a || $urandom_range(0, 1) == 1) rr = rr | own;
            if (c == a || (c > a && $urandom_range(0, 1) == 1)) mv = mv | own;
            if (c > a) sd = (kind == 0) && (c == s);
          end
          1: begin
            if (c < a) rr = rr | own;
          end
          default: rr = rr | own;
        endcase
        set_in(d, rr, mv, sd);
        @(negedge clk);
      end
      set_in(d, 4'b0000, 4'b0000, 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  // Monitor: per-cycle invariants and one scoreboard pop per grant episode.
  task automatic monitor(input int d);
    logic [3:0] prev, g;
    int own, len;
    exp_t e;
    prev = 4'b0000; own = 0; len = 0;
    forever begin
      @(posedge clk);
      #1;
      g = gnt_of(d);
      if (mon_en) begin
        check($sformatf("dut%0d_onehot0", d), int'($onehot0(g)), 1);
        check($sformatf("dut%0d_bus_busy", d), int'(busy_of(d)), int'(g != 4'b0000));
        if (g != 4'b0000 && prev == 4'b0000) begin
          own = idx_of(g);
          len = 1;
          check($sformatf("dut%0d_grant_id", d), int'(gid_of(d)), own);
          check($sformatf("dut%0d_terr_granted", d), int'(terr_of(d)), 0);
        end else if (g != 4'b0000) begin
          len++;
          check($sformatf("dut%0d_grant_stable", d), int'(g), int'(prev));
          check($sformatf("dut%0d_terr_granted", d), int'(terr_of(d)), 0);
        end else if (prev != 4'b0000) begin
          if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            n_checks++;
            n_fail++;
            $display("FAIL dut%0d_unexpected_grant: owner %0d len %0d", d, own, len);
          end else begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            check($sformatf("dut%0d_owner", d), own, e.owner);
            check($sformatf("dut%0d_grant_len", d), len, e.len);
            check($sformatf("dut%0d_timeout_err", d), int'(terr_of(d)), int'(e.terr));
            check($sformatf("dut%0d_grant_id_hold", d), int'(gid_of(d)), e.owner);
          end
        end else begin
          check($sformatf("dut%0d_terr_idle", d), int'(terr_of(d)), 0);
        end
      end
      prev = g;
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    reset = 1'b1;
    set_in(0, 4'b0000, 4'b0000, 1'b0);
    set_in(1, 4'b0000, 4'b0000, 1'b0);
    #12;
    check("rst_grant0", int'(gnt0), 0);
    check("rst_gid0", int'(gid0), 0);
    check("rst_busy0", int'(busy0), 0);
    check("rst_terr0", int'(terr0), 0);
    check("rst_grant1", int'(gnt1), 0);
    check("rst_gid1", int'(gid1), 0);
    check("rst_busy1", int'(busy1), 0);
    check("rst_terr1", int'(terr1), 0);
    @(negedge clk);
    reset = 1'b0;

    fork
      drive(0);
      drive(1);
    join

    repeat (4) @(negedge clk);
    check("dut0_queue_empty", q0.size(), 0);
    check("dut1_queue_empty", q1.size(), 0);
    mon_en = 1'b0;

    // Reset during a BUSY transaction owned by master 1 of the round-robin arbiter.
    set_in(1, 4'b0010, 4'b0000, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (gnt1 != 3'b000) begin ok = 1'b1; break; end
    end
    check("pre_rst_grant1", int'(gnt1), 2);
    set_in(1, 4'b0010, 4'b0010, 1'b0);
    @(negedge clk);
    set_in(1, 4'b0010, 4'b0000, 1'b0);
    @(negedge clk);
    check("pre_rst_busy1", int'(busy1), 1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_grant1", int'(gnt1), 0);
    check("mid_rst_busy1", int'(busy1), 0);
    check("mid_rst_gid1", int'(gid1), 0);
    check("mid_rst_terr1", int'(terr1), 0);
    check("mid_rst_grant0", int'(gnt0), 0);
    @(negedge clk);
    reset = 1'b0;
    set_in(1, 4'b0110, 4'b0000, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (gnt1 != 3'b000) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now("post_rst_wait_grant");
    check("post_rst_grant1", int'(gnt1), 2);
    check("post_rst_gid1", int'(gid1), 1);
    set_in(1, 4'b0000, 4'b0000, 1'b0);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
